// File: rtl/count_seeker.sv
// Seek controller for one up/down saturating counter: steers EN/UP_DWN until COUNT matches a target.
// Optional SEEK_ABORT_EN adds an ABORT input that cancels an in-progress seek with ERROR.
module count_seeker #(
  parameter int COUNTER_SIZE = 16,
  parameter int STALL_LIMIT  = 8,
  parameter int STALL_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [COUNTER_SIZE-1:0] CMD_TARGET,
  input  logic [COUNTER_SIZE-1:0] COUNT_IN,
`ifdef SEEK_ABORT_EN
  input  logic                    ABORT,
`endif
  output logic                    EN_OUT,
  output logic                    UP_DWN_OUT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR
);

  typedef enum logic [1:0] {IDLE, SEEK, DONE_ST, ERR_ST} state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  state_t                  state;
  logic [COUNTER_SIZE-1:0] target_p0;
  logic [COUNTER_SIZE-1:0] count_p1;
  logic [STALL_W-1:0]      stall_cnt;
  logic [STALL_W-1:0]      stall_next;
  logic                    first_p0;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    abort_req;
  logic                    at_target;
  logic                    stalled;

`ifdef SEEK_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  // busy_q is high exactly in SEEK, so the steering outputs fall to 0 in every other state
  assign at_target  = (COUNT_IN == target_p0);
  assign EN_OUT     = busy_q & ~at_target & ~abort_req;
  assign UP_DWN_OUT = busy_q & (COUNT_IN < target_p0);
  assign stalled    = EN_OUT & ~first_p0 & (COUNT_IN == count_p1);
  assign stall_next = stall_cnt + STALL_W'(1);

  assign CMD_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;

  // Stage p1: previous-cycle count for stall detection
  always_ff @(posedge CLK) begin
    count_p1 <= COUNT_IN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      target_p0 <= '0;
      stall_cnt <= '0;
      first_p0  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID && ready_q) begin
            target_p0 <= CMD_TARGET;
            stall_cnt <= '0;
            first_p0  <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state     <= SEEK;
          end
        end
        SEEK: begin
          first_p0 <= 1'b0;
          // Reaching the target outranks both abort and a stall trip in the same cycle
          if (at_target) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE_ST;
          end else if (abort_req || (stalled && stall_next == STALL_MAX)) begin
            busy_q    <= 1'b0;
            error_q   <= 1'b1;
            stall_cnt <= '0;
            state     <= ERR_ST;
          end else if (stalled) begin
            stall_cnt <= stall_next;
          end else begin
            stall_cnt <= '0;
          end
        end
        DONE_ST, ERR_ST: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seeker.sv
// Bench for count_seeker: behavioural saturating counter attached, scoreboard of expected seek outcomes.
module tb_count_seeker;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cnt;
  logic         en_out;
  logic         up_dwn_out;
  logic         busy;
  logic         done;
  logic         error;
  logic         cnt_rst;
  logic         ld;
  logic [W-1:0] ld_val;
`ifdef SEEK_ABORT_EN
  logic         abort;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit           err;
    logic [W-1:0] count;
    int           lat;
    int           en;
    bit           up;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  count_seeker #(.COUNTER_SIZE(W), .STALL_LIMIT(8), .STALL_W(4)) dut (
    .CLK        (clk),
    .RST        (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_TARGET (cmd_target),
    .COUNT_IN   (cnt),
`ifdef SEEK_ABORT_EN
    .ABORT      (abort),
`endif
    .EN_OUT     (en_out),
    .UP_DWN_OUT (up_dwn_out),
    .BUSY       (busy),
    .DONE       (done),
    .ERROR      (error)
  );

  // Attached 16-bit up/down saturating counter with its own reset and a load port
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_rst)
      cnt <= '0;
    else if (ld)
      cnt <= ld_val;
    else if (en_out) begin
      if (up_dwn_out) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
      end else begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks accept time, EN cycles and direction; checks each DONE/ERROR against the queue head
  int   acc_cyc = 0;
  int   en_cnt  = 0;
  int   dir_bad = 0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      en_cnt  = 0;
      dir_bad = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc + 1;
        en_cnt  = 0;
        dir_bad = 0;
      end
      if (en_out) begin
        en_cnt++;
        if (sb.size() > 0 && up_dwn_out !== sb[0].up) dir_bad++;
      end
      if (done || error) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("error_flag", {31'd0, error}, {31'd0, e.err});
          chk("done_flag", {31'd0, done}, {31'd0, !e.err});
          chk("final_count", {16'd0, cnt}, {16'd0, e.count});
          chk("latency", cyc - acc_cyc + 1, e.lat);
          chk("en_cycles", en_cnt, e.en);
          chk("direction", dir_bad, 0);
          chk("en_in_pulse", {31'd0, en_out}, 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seek(input bit err, input logic [W-1:0] c, input int lat,
                             input int en, input bit up);
    exp_t x;
    x.err   = err;
    x.count = c;
    x.lat   = lat;
    x.en    = en;
    x.up    = up;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [W-1:0] t);
    bit ok;
    ok         = 1'b0;
    cmd_target = t;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sb.size() == 0 && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("seek_complete", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cnt == v) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("reach_count", {31'd0, ok}, 32'd1);
  endtask

  task automatic load(input logic [W-1:0] v);
    ld_val = v;
    ld     = 1'b1;
    step();
    ld     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cnt_rst    = 1'b1;
    ld         = 1'b0;
    ld_val     = '0;
`ifdef SEEK_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_en", {31'd0, en_out}, 32'd0);
    chk("rst_updwn", {31'd0, up_dwn_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst     = 1'b0;
    cnt_rst = 1'b0;
    step();

    // Count up 0 -> 20: 20 up steps, DONE in cycle 22 after accept
    expect_seek(1'b0, 16'd20, 22, 20, 1'b1);
    issue(16'd20);
    wait_idle();
    repeat (3) step();
    chk("hold_20", {16'd0, cnt}, 32'd20);
    chk("idle_en", {31'd0, en_out}, 32'd0);

    // Count down 20 -> 5, then a zero-distance command queued behind it
    expect_seek(1'b0, 16'd5, 17, 15, 1'b0);
    issue(16'd5);
    expect_seek(1'b0, 16'd5, 2, 0, 1'b0);
    issue(16'd5);
    wait_idle();

    // Full-range targets at both saturation ends
    load(16'hFFF0);
    expect_seek(1'b0, 16'hFFFF, 17, 15, 1'b1);
    issue(16'hFFFF);
    wait_idle();
    repeat (3) step();
    chk("hold_ffff", {16'd0, cnt}, 32'h0000FFFF);
    load(16'h0010);
    expect_seek(1'b0, 16'h0000, 18, 16, 1'b0);
    issue(16'h0000);
    wait_idle();
    chk("hold_0", {16'd0, cnt}, 32'd0);

    // Stall: counter reset held once it reaches 10; 8 frozen cycles then ERROR
    expect_seek(1'b1, 16'd0, 21, 20, 1'b1);
    issue(16'd100);
    wait_cnt(16'd10);
    cnt_rst = 1'b1;
    wait_idle();
    cnt_rst = 1'b0;
    chk("ready_after_err", {31'd0, cmd_ready}, 32'd1);

    // Reset mid-seek at COUNT=7; no pulse may follow
    issue(16'd20);
    wait_cnt(16'd7);
    rst = 1'b1;
    step();
    chk("midrst_en", {31'd0, en_out}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_updwn", {31'd0, up_dwn_out}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("cnt_after_rst", {16'd0, cnt}, 32'd8);
    expect_seek(1'b0, 16'd3, 7, 5, 1'b0);
    issue(16'd3);
    wait_idle();

`ifdef SEEK_ABORT_EN
    // Abort at COUNT=3 of a seek to 50
    load(16'd0);
    expect_seek(1'b1, 16'd3, 5, 3, 1'b1);
    issue(16'd50);
    wait_cnt(16'd3);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_en", {31'd0, en_out}, 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle();
    repeat (2) step();
    chk("abort_hold", {16'd0, cnt}, 32'd3);
`endif

    chk("queue_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
